// File: rtl/dfp_bmem_adapter.sv
// dfp_bmem_adapter
// Bridges one 256-bit cache DFP port to the 64-bit burst bmem interface.
// It serialises a line write into four consecutive beats, issues one read
// request per line, and collects tagged read beats into a full line. Only
// one transaction is in flight at a time. bmem_* outputs are combinational
// from state, counter and request inputs. dfp_rdata, dfp_resp and busy are
// registered.

module dfp_bmem_adapter #(
  parameter int ADDR_WIDTH = 32,
  parameter int BEAT_WIDTH = 64,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] dfp_addr,
  input  logic                  dfp_read,
  input  logic                  dfp_write,
  input  logic [LINE_WIDTH-1:0] dfp_wdata,
  output logic [LINE_WIDTH-1:0] dfp_rdata,
  output logic                  dfp_resp,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BEAT_WIDTH-1:0] bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [ADDR_WIDTH-1:0] bmem_raddr,
  input  logic [BEAT_WIDTH-1:0] bmem_rdata,
  input  logic                  bmem_rvalid
);

  localparam int BEATS    = LINE_WIDTH / BEAT_WIDTH;
  localparam int OFF_BITS = $clog2(LINE_WIDTH / 8);

  // The beat counter is two bits wide, which fixes the line at four beats.
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WR_BEAT = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  // This mask clears the byte offset so that bmem only ever sees line-aligned addresses.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    {{(ADDR_WIDTH-OFF_BITS){1'b1}}, {OFF_BITS{1'b0}}};

  logic [1:0]                       state_r;
  logic [1:0]                       state_next_s;
  logic [1:0]                       cnt_r;
  logic [1:0]                       cnt_next_s;
  logic [ADDR_WIDTH-1:0]            tag_r;
  logic [LINE_WIDTH-BEAT_WIDTH-1:0] line_r;
  logic [LINE_WIDTH-1:0]            dfp_rdata_r;
  logic                             dfp_resp_r;
  logic                             busy_r;

  logic [ADDR_WIDTH-1:0]            aligned_addr_s;
  logic                             accept_wr_s;
  logic                             accept_rd_s;
  logic                             beat_hit_s;

  assign aligned_addr_s = dfp_addr & LINE_MASK;

  // Write has priority when both requests are raised at the same time, although that case is illegal.
  assign accept_wr_s = (state_r == IDLE) && dfp_write && bmem_ready;
  assign accept_rd_s = (state_r == IDLE) && !dfp_write && dfp_read && bmem_ready;

  // A beat counts only while waiting on a read and only when its tag matches the outstanding line.
  assign beat_hit_s  = (state_r == RD_WAIT) && bmem_rvalid && (bmem_raddr == tag_r);

  // Next-state and beat-counter logic.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_wr_s) begin
          state_next_s = WR_BEAT;
          cnt_next_s   = 2'd1;
        end else if (accept_rd_s) begin
          state_next_s = RD_WAIT;
          cnt_next_s   = 2'd0;
        end else begin
          state_next_s = IDLE;
          cnt_next_s   = 2'd0;
        end
      end
      WR_BEAT: begin
        cnt_next_s = cnt_r + 2'd1;
        if (cnt_r == LAST_BEAT) begin
          state_next_s = RESP;
        end else begin
          state_next_s = WR_BEAT;
        end
      end
      RD_WAIT: begin
        if (beat_hit_s) begin
          cnt_next_s = cnt_r + 2'd1;
          if (cnt_r == LAST_BEAT) begin
            state_next_s = RESP;
          end else begin
            state_next_s = RD_WAIT;
          end
        end else begin
          state_next_s = RD_WAIT;
        end
      end
      RESP: begin
        state_next_s = IDLE;
        cnt_next_s   = 2'd0;
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = 2'd0;
      end
    endcase
  end

  // Drive bmem requests and beats; everything is held at zero while reset is asserted.
  always_comb begin
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = {ADDR_WIDTH{1'b0}};
    bmem_wdata = {BEAT_WIDTH{1'b0}};
    if (rst) begin
      case (state_r)
        IDLE: begin
          if (accept_wr_s) begin
            bmem_write = 1'b1;
            bmem_addr  = aligned_addr_s;
            bmem_wdata = dfp_wdata[BEAT_WIDTH-1:0];
          end else if (accept_rd_s) begin
            bmem_read  = 1'b1;
            bmem_addr  = aligned_addr_s;
          end else begin
            bmem_read  = 1'b0;
            bmem_write = 1'b0;
          end
        end
        WR_BEAT: begin
          bmem_write = 1'b1;
          bmem_addr  = tag_r;
          bmem_wdata = dfp_wdata[int'(cnt_r) * BEAT_WIDTH +: BEAT_WIDTH];
        end
        default: begin
          bmem_read  = 1'b0;
          bmem_write = 1'b0;
        end
      endcase
    end else begin
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
    end
  end

  // Sequential state: FSM, counter, tag, beat buffer and the registered DFP outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= 2'd0;
      tag_r       <= {ADDR_WIDTH{1'b0}};
      line_r      <= {(LINE_WIDTH-BEAT_WIDTH){1'b0}};
      dfp_rdata_r <= {LINE_WIDTH{1'b0}};
      dfp_resp_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      dfp_resp_r <= (state_next_s == RESP);
      busy_r     <= (state_next_s != IDLE);
      if (accept_wr_s || accept_rd_s) begin
        tag_r <= aligned_addr_s;
      end
      if (beat_hit_s) begin
        if (cnt_r == LAST_BEAT) begin
          // The final beat goes straight to the output register, so the full line is valid during RESP.
          dfp_rdata_r <= {bmem_rdata, line_r};
        end else begin
          line_r[int'(cnt_r) * BEAT_WIDTH +: BEAT_WIDTH] <= bmem_rdata;
        end
      end
    end
  end

  assign dfp_rdata = dfp_rdata_r;
  assign dfp_resp  = dfp_resp_r;
  assign busy      = busy_r;

endmodule
